dcache_nway: RTL and testbench
==============================

# dcache_nway

Parametrised N-way set-associative, write-back, write-allocate data cache sitting between the core's dbus and the cbus interconnect. It generalises the line length, set count and associativity, and uses a true-LRU age replacement. It adds a hardware invalidation sweep after reset and a bypass path for uncached MMIO addresses. Hits complete in the request cycle; misses write back a dirty victim, refill the line, then complete.

## Interface
- `WORDS_PER_LINE`, default 16: 64-bit words per line; power of 2, 2..16.
- `SETS`, default 8: number of sets; power of 2, ≥2.
- `WAYS`, default 4: associativity; power of 2, 2..8.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `dreq`  in  dbus_req_t  fields: valid, addr, size, strobe, data. Held stable by the core until `dresp.addr_ok`.
- `dresp`  out  dbus_resp_t  fields: addr_ok, data_ok, data.
- `creq`  out  cbus_req_t  fields: valid, is_write, size, addr, strobe, data, len, burst.
- `cresp`  in  cbus_resp_t  fields: ready, last, data.
- `hit_cnt`, `miss_cnt`  out  32 each  present only with `DCACHE_STATS_EN`.

## Operation
- Address split: [2:0] byte, then log2(WORDS_PER_LINE) offset bits, then log2(SETS) index bits. Tag is the remainder up to bit 63.
- Per way metadata: valid, dirty, tag, and a log2(WAYS)-bit age.
- Data RAM and meta RAM are single-port with read latency 0.
- States: SWEEP, LOOKUP, WRITEBACK, REFILL, UNCACHED.
- SWEEP
  - Entered on reset. A counter walks sets 0..SETS-1, one set per cycle, clearing valid and dirty.
  - Age of way i is set to i.
  - Moves to LOOKUP after set SETS-1.
- LOOKUP with `dreq.valid`:
  - `addr[31]==0`: go to UNCACHED.
  - Hit, read: assert addr_ok and data_ok; `data` is the word.
  - Hit, write: `strobe` bytes are merged; dirty is set.
  - Miss: choose a victim. The victim is the lowest-index invalid way; if all ways are valid, it is the way with age WAYS-1. The victim is latched. Go to WRITEBACK if the victim is valid and dirty, else REFILL.
- WRITEBACK
  - creq: is_write=1, addr = {victim tag, index, zero offset, 3'b0}, size MSIZE8, strobe 8'hFF, len = code for WORDS_PER_LINE beats, burst INCR.
  - data = victim word[beat]. The beat counter advances on `cresp.ready`.
  - `ready & last` clears dirty and goes to REFILL.
- REFILL
  - creq: is_write=0, addr = line base of dreq.addr, same size/len/burst.
  - Each `ready` beat writes `cresp.data` into word[beat].
  - On `last`: valid=1, dirty=0, tag written; return to LOOKUP, which then hits.
- UNCACHED
  - creq carries dreq's addr, size, strobe, data; len MLEN1; burst FIXED; is_write = |strobe.
  - On `cresp.ready & last`: addr_ok=data_ok=1, data=cresp.data; return to LOOKUP.
  - Caches and ages are untouched.
- Age update, only on a completed cached access to way h: every way with age < age[h] increments; age[h] becomes 0. Ages stay a permutation of 0..WAYS-1.

## Timing
- Reset values: state SWEEP, all dresp fields 0, creq.valid 0, beat counter 0, counters 0.
- `reset` asserted mid-burst drops creq.valid immediately; the interconnect is reset together with the cache.
- addr_ok and data_ok are always asserted together, in the completion cycle only. They are held 0 during SWEEP.
- Hit latency is 0 cycles.
- Clean miss completes in 1 + WORDS_PER_LINE beats + 1 cycle, plus interconnect wait states.
- Dirty miss adds WORDS_PER_LINE write beats.
- creq fields hold stable while creq.valid=1 and ready=0.
- `dreq.valid` low in LOOKUP: no state or age change.

## Configuration
- `DCACHE_STATS_EN` defined:
  - `hit_cnt` increments on each hit completion, excluding the post-refill completion.
  - `miss_cnt` increments on each miss decision.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: the ports and logic are absent, with no behavioural difference.

## Test plan
- After reset: addr_ok stays 0 for exactly SETS cycles. Then a read of 0x8000_0000 misses and does a 16-beat REFILL returning 0x11..; the next read of the same address hits with data_ok in the same cycle.
- Write 0x8000_0008 with strobe 0x0F and data 0xAAAA_BBBB_CCCC_DDDD over a line of 0x11..: the readback is 0x1111_1111_CCCC_DDDD.
- WAYS=4: fill one set with four tags, touch tags 0, 2, 3, then miss a fifth tag. Tag 1's way is replaced; if dirty, 16 write beats go to its address before the refill.
- Uncached write to 0x1000_0000, size 4, strobe 0x0F: a single creq beat with burst FIXED, len MLEN1, is_write=1; data_ok on `last`; hit/miss counters unchanged.
- Assert `reset` at REFILL beat 7: creq.valid is 0 in the same cycle, SWEEP reruns, and a re-read of the same line misses again.

Source files
------------

// File: rtl/dcache_nway.sv
// rtl/dcache_nway.sv - N-way set-associative write-back data cache with LRU ages, reset sweep and MMIO bypass
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.

package dcache_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [3:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    localparam logic [2:0] MSIZE1 = 3'd0, MSIZE2 = 3'd1, MSIZE4 = 3'd2, MSIZE8 = 3'd3;
    localparam logic [3:0] MLEN1 = 4'd0, MLEN2 = 4'd1, MLEN4 = 4'd3, MLEN8 = 4'd7, MLEN16 = 4'd15;
    localparam logic [1:0] BURST_FIXED = 2'd0, BURST_INCR = 2'd1;
endpackage

module dcache_nway
    import dcache_pkg::*;
#(
    parameter int WORDS_PER_LINE = 16,
    parameter int SETS           = 8,
    parameter int WAYS           = 4
)(
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output cbus_req_t  creq,
    input  cbus_resp_t cresp
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int OFS_W    = $clog2(WORDS_PER_LINE);
    localparam int IDX_W    = $clog2(SETS);
    localparam int WAY_W    = $clog2(WAYS);
    localparam int LINE_LSB = 3 + OFS_W;
    localparam int TAG_LSB  = LINE_LSB + IDX_W;
    localparam int TAG_W    = 64 - TAG_LSB;
    localparam logic [3:0] LINE_LEN = 4'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {S_SWEEP, S_LOOKUP, S_WRITEBACK, S_REFILL, S_UNCACHED} state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_sweep_idx;
    logic [OFS_W-1:0]   r_beat;
    logic [WAY_W-1:0]   r_victim;

    logic               r_valid [SETS][WAYS];
    logic               r_dirty [SETS][WAYS];
    logic [TAG_W-1:0]   r_tag   [SETS][WAYS];
    logic [WAY_W-1:0]   r_age   [SETS][WAYS];
    logic [63:0]        r_data  [SETS][WAYS][WORDS_PER_LINE];

    logic [IDX_W-1:0]   w_idx;
    logic [OFS_W-1:0]   w_ofs;
    logic [TAG_W-1:0]   w_tag;
    logic               w_cached;
    logic               w_hit;
    logic [WAY_W-1:0]   w_hit_way;
    logic               w_inv_found;
    logic [WAY_W-1:0]   w_inv_way;
    logic [WAY_W-1:0]   w_lru_way;
    logic [WAY_W-1:0]   w_victim;
    logic               w_hit_done;
    logic               w_unc_done;

    assign w_idx      = dreq.addr[TAG_LSB-1 -: IDX_W];
    assign w_ofs      = dreq.addr[3 +: OFS_W];
    assign w_tag      = dreq.addr[63 -: TAG_W];
    assign w_cached   = dreq.addr[31];
    assign w_victim   = w_inv_found ? w_inv_way : w_lru_way;
    assign w_hit_done = (r_state == S_LOOKUP) && dreq.valid && w_cached && w_hit;
    assign w_unc_done = (r_state == S_UNCACHED) && cresp.ready && cresp.last;

    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        w_lru_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
            if (!r_valid[w_idx][w] && !w_inv_found) begin
                w_inv_found = 1'b1;
                w_inv_way   = WAY_W'(w);
            end
            if (r_age[w_idx][w] == WAY_W'(WAYS - 1)) begin
                w_lru_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        dresp         = '0;
        dresp.addr_ok = w_hit_done || w_unc_done;
        dresp.data_ok = w_hit_done || w_unc_done;
        if (w_hit_done) begin
            dresp.data = r_data[w_idx][w_hit_way][w_ofs];
        end else if (w_unc_done) begin
            dresp.data = cresp.data;
        end
    end

    // creq is a pure function of state, so an async reset drops valid immediately
    always_comb begin
        creq = '0;
        case (r_state)
            S_WRITEBACK: begin
                creq.valid    = 1'b1;
                creq.is_write = 1'b1;
                creq.size     = MSIZE8;
                creq.addr     = {r_tag[w_idx][r_victim], w_idx, {OFS_W{1'b0}}, 3'b000};
                creq.strobe   = 8'hFF;
                creq.data     = r_data[w_idx][r_victim][r_beat];
                creq.len      = LINE_LEN;
                creq.burst    = BURST_INCR;
            end
            S_REFILL: begin
                creq.valid    = 1'b1;
                creq.size     = MSIZE8;
                creq.addr     = {dreq.addr[63:LINE_LSB], {LINE_LSB{1'b0}}};
                creq.len      = LINE_LEN;
                creq.burst    = BURST_INCR;
            end
            S_UNCACHED: begin
                creq.valid    = 1'b1;
                creq.is_write = |dreq.strobe;
                creq.size     = dreq.size;
                creq.addr     = dreq.addr;
                creq.strobe   = dreq.strobe;
                creq.data     = dreq.data;
                creq.len      = MLEN1;
                creq.burst    = BURST_FIXED;
            end
            default: ;
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic        r_refilled;
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;
    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_SWEEP;
            r_sweep_idx <= '0;
            r_beat      <= '0;
            r_victim    <= '0;
`ifdef DCACHE_STATS_EN
            r_refilled  <= 1'b0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
`endif
        end else begin
            case (r_state)
                S_SWEEP: begin
                    r_sweep_idx <= r_sweep_idx + 1'b1;
                    if (r_sweep_idx == IDX_W'(SETS - 1)) begin
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (dreq.valid) begin
                        if (!w_cached) begin
                            r_state <= S_UNCACHED;
                        end else if (w_hit) begin
`ifdef DCACHE_STATS_EN
                            // the completion right after a refill was already counted as a miss
                            if (!r_refilled) begin
                                r_hit_cnt <= r_hit_cnt + 1'b1;
                            end
                            r_refilled <= 1'b0;
`endif
                        end else begin
                            r_victim <= w_victim;
                            r_beat   <= '0;
                            r_state  <= (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim])
                                        ? S_WRITEBACK : S_REFILL;
`ifdef DCACHE_STATS_EN
                            r_miss_cnt <= r_miss_cnt + 1'b1;
`endif
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (cresp.ready) begin
                        r_beat <= r_beat + 1'b1;
                        if (cresp.last) begin
                            r_beat  <= '0;
                            r_state <= S_REFILL;
                        end
                    end
                end
                S_REFILL: begin
                    if (cresp.ready) begin
                        r_beat <= r_beat + 1'b1;
                        if (cresp.last) begin
                            r_beat  <= '0;
                            r_state <= S_LOOKUP;
`ifdef DCACHE_STATS_EN
                            r_refilled <= 1'b1;
`endif
                        end
                    end
                end
                S_UNCACHED: begin
                    if (cresp.ready && cresp.last) begin
                        r_state <= S_LOOKUP;
                    end
                end
                default: r_state <= S_SWEEP;
            endcase
        end
    end

    // RAM-style arrays carry no reset; the sweep invalidates them instead
    always_ff @(posedge clk) begin
        case (r_state)
            S_SWEEP: begin
                for (int w = 0; w < WAYS; w++) begin
                    r_valid[r_sweep_idx][w] <= 1'b0;
                    r_dirty[r_sweep_idx][w] <= 1'b0;
                    r_age[r_sweep_idx][w]   <= WAY_W'(w);
                end
            end
            S_LOOKUP: begin
                if (w_hit_done) begin
                    for (int w = 0; w < WAYS; w++) begin
                        if (r_age[w_idx][w] < r_age[w_idx][w_hit_way]) begin
                            r_age[w_idx][w] <= r_age[w_idx][w] + 1'b1;
                        end
                    end
                    r_age[w_idx][w_hit_way] <= '0;
                    for (int b = 0; b < 8; b++) begin
                        if (dreq.strobe[b]) begin
                            r_data[w_idx][w_hit_way][w_ofs][8*b +: 8] <= dreq.data[8*b +: 8];
                        end
                    end
                    if (|dreq.strobe) begin
                        r_dirty[w_idx][w_hit_way] <= 1'b1;
                    end
                end
            end
            S_WRITEBACK: begin
                if (cresp.ready && cresp.last) begin
                    r_dirty[w_idx][r_victim] <= 1'b0;
                end
            end
            S_REFILL: begin
                if (cresp.ready) begin
                    r_data[w_idx][r_victim][r_beat] <= cresp.data;
                    if (cresp.last) begin
                        r_valid[w_idx][r_victim] <= 1'b1;
                        r_dirty[w_idx][r_victim] <= 1'b0;
                        r_tag[w_idx][r_victim]   <= w_tag;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dcache_nway.sv
// tb/tb_dcache_nway.sv - randomized self-checking bench for dcache_nway against a timestamp-LRU reference model
// Build with DCACHE_STATS_EN defined to also check the hit/miss counters.

module tb_dcache_nway;
    import dcache_pkg::*;

    localparam int WPL  = 16;
    localparam int SETS = 8;
    localparam int WAYS = 4;
    localparam int LIMIT = 2000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    cbus_req_t  creq;
    cbus_resp_t cresp;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    always #5 clk = ~clk;

    dcache_nway #(.WORDS_PER_LINE(WPL), .SETS(SETS), .WAYS(WAYS)) dut (
        .clk   (clk),
        .reset (rst_n),
        .dreq  (dreq),
        .dresp (dresp),
        .creq  (creq),
        .cresp (cresp)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // backing memory (interconnect side) and core-visible reference memory
    logic [63:0] mem     [logic [63:0]];
    logic [63:0] ref_mem [logic [63:0]];

    function automatic logic [63:0] dflt(input logic [63:0] a);
        logic [63:0] r;
        if (a[31:7] == 25'h100_0000) r = 64'h1111_1111_1111_1111;
        else                         r = {a[31:0] ^ 32'hC0DE_0000, ~a[31:0]};
        return r;
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] r = old;
        for (int b = 0; b < 8; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : dflt(a);
    endfunction

    function automatic logic [63:0] ref_rd(input logic [63:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    // interconnect slave: random wait states, answers on the falling edge
    int          s_beat = 0;
    int          s_waits = 0;
    int          s_wr_beats = 0;
    logic [63:0] s_wb_addr = '0;
    cbus_req_t   s_last;

    initial begin
        logic [63:0] wa;
        cresp = '0;
        s_last = '0;
        forever begin
            @(negedge clk);
            cresp = '0;
            if (!rst_n) begin
                s_beat = 0;
            end else if (creq.valid) begin
                if ($urandom_range(0, 3) != 0) begin
                    wa = (creq.burst == BURST_INCR) ? creq.addr + 64'(s_beat) * 8 : creq.addr;
                    wa = {wa[63:3], 3'b000};
                    cresp.ready = 1'b1;
                    cresp.last  = (s_beat == int'(creq.len));
                    if (creq.is_write) begin
                        mem[wa] = merge(mem_rd(wa), creq.data, creq.strobe);
                        s_wr_beats++;
                        if (s_beat == 0 && creq.burst == BURST_INCR) s_wb_addr = creq.addr;
                    end else begin
                        cresp.data = mem_rd(wa);
                    end
                    s_last = creq;
                    s_beat = cresp.last ? 0 : s_beat + 1;
                end else begin
                    s_waits++;
                end
            end
        end
    end

    // reference cache: resident lines per set, evicting the oldest access timestamp
    logic [53:0] m_tag   [SETS][WAYS];
    bit          m_val   [SETS][WAYS];
    bit          m_dirty [SETS][WAYS];
    int          m_stamp [SETS][WAYS];
    int          now = 0;
    int          exp_hits = 0;
    int          exp_misses = 0;

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) for (int w = 0; w < WAYS; w++) m_val[s][w] = 0;
        ref_mem.delete();
        foreach (mem[k]) ref_mem[k] = mem[k];
        exp_hits = 0;
        exp_misses = 0;
    endtask

    task automatic access(input logic [63:0] a, input logic [7:0] strb, input logic [63:0] d,
                          input logic [2:0] sz, input int extra, input string tag,
                          output logic [63:0] rdata, output logic [63:0] wb_addr);
        logic [63:0] wa = {a[63:3], 3'b000};
        int          idx = int'(a[9:7]);
        logic [53:0] t = a[63:10];
        bit          hit = 0, wb = 0;
        int          slot = -1;
        logic [63:0] exp_wb = '0;
        logic [63:0] exp_rd = ref_rd(wa);
        int          cyc = 0, w0, b0, waits, wbeats, exp_cyc;
        if (a[31]) begin
            for (int w = 0; w < WAYS; w++) if (m_val[idx][w] && m_tag[idx][w] == t) begin hit = 1; slot = w; end
            if (!hit) begin
                for (int w = 0; w < WAYS; w++) if (!m_val[idx][w] && slot < 0) slot = w;
                if (slot < 0) begin
                    slot = 0;
                    for (int w = 1; w < WAYS; w++) if (m_stamp[idx][w] < m_stamp[idx][slot]) slot = w;
                    wb = m_dirty[idx][slot];
                    exp_wb = {m_tag[idx][slot], 3'(idx), 7'b0};
                end
                m_val[idx][slot] = 1; m_tag[idx][slot] = t; m_dirty[idx][slot] = 0;
                exp_misses++;
            end else begin
                exp_hits++;
            end
            now++;
            m_stamp[idx][slot] = now;
            if (strb != 0) m_dirty[idx][slot] = 1;
        end
        if (strb != 0) ref_mem[wa] = merge(exp_rd, d, strb);

        w0 = s_waits;
        b0 = s_wr_beats;
        dreq.valid = 1'b1; dreq.addr = a; dreq.size = sz; dreq.strobe = strb; dreq.data = d;
        #1;
        while (!dresp.addr_ok && cyc < LIMIT) begin
            @(negedge clk); #1; cyc++;
        end
        if (cyc >= LIMIT) check({tag, "_timeout"}, 0, 1);
        check({tag, "_dataok"}, dresp.data_ok, 1);
        rdata  = dresp.data;
        wb_addr = s_wb_addr;
        waits  = s_waits - w0;
        wbeats = s_wr_beats - b0;
        if (!a[31])   exp_cyc = extra + 1 + waits;
        else if (hit) exp_cyc = extra;
        else          exp_cyc = extra + 1 + WPL + waits + (wb ? WPL : 0);
        check({tag, "_lat"}, cyc, exp_cyc);
        if (strb == 0) check({tag, "_rd"}, rdata, exp_rd);
        if (a[31] && !hit) check({tag, "_wbbeats"}, wbeats, wb ? WPL : 0);
        if (wb) check({tag, "_wbaddr"}, wb_addr, exp_wb);
        @(posedge clk);
        @(negedge clk);
        dreq.valid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] rd, wba, a, d, t1base;
        logic [7:0]  s;
        int          n;

        dreq = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_addr_ok", dresp.addr_ok, 0);
        check("rst_data_ok", dresp.data_ok, 0);
        check("rst_data", dresp.data, 0);
        check("rst_creq_valid", creq.valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        access(64'h8000_0000, 8'h00, 64'h0, MSIZE8, SETS, "first_miss", rd, wba);
        check("first_data", rd, 64'h1111_1111_1111_1111);
        access(64'h8000_0000, 8'h00, 64'h0, MSIZE8, 0, "first_hit", rd, wba);
        access(64'h8000_0008, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD, MSIZE8, 0, "merge_wr", rd, wba);
        access(64'h8000_0008, 8'h00, 64'h0, MSIZE8, 0, "merge_rd", rd, wba);
        check("merge_val", rd, 64'h1111_1111_CCCC_DDDD);

        // set 2: fill four tags, dirty the second, touch 1st/3rd/4th, then a fifth tag evicts the second
        t1base = 64'h8000_0100 + (64'd2 << 10);
        access(64'h8000_0100 + (64'd1 << 10), 8'h00, 64'h0, MSIZE8, 0, "lru_f0", rd, wba);
        access(t1base + 64'h18, 8'hFF, 64'h0123_4567_89AB_CDEF, MSIZE8, 0, "lru_f1", rd, wba);
        access(64'h8000_0100 + (64'd3 << 10), 8'h00, 64'h0, MSIZE8, 0, "lru_f2", rd, wba);
        access(64'h8000_0100 + (64'd4 << 10), 8'h00, 64'h0, MSIZE8, 0, "lru_f3", rd, wba);
        access(64'h8000_0100 + (64'd1 << 10), 8'h00, 64'h0, MSIZE8, 0, "lru_t0", rd, wba);
        access(64'h8000_0100 + (64'd3 << 10), 8'h00, 64'h0, MSIZE8, 0, "lru_t2", rd, wba);
        access(64'h8000_0100 + (64'd4 << 10), 8'h00, 64'h0, MSIZE8, 0, "lru_t3", rd, wba);
        access(64'h8000_0100 + (64'd5 << 10), 8'h00, 64'h0, MSIZE8, 0, "lru_new", rd, wba);
        check("lru_victim", wba, t1base);
        access(t1base + 64'h18, 8'h00, 64'h0, MSIZE8, 0, "lru_back", rd, wba);
        check("lru_back_val", rd, 64'h0123_4567_89AB_CDEF);

        access(64'h1000_0000, 8'h0F, 64'hDEAD_BEEF_0123_4567, MSIZE4, 0, "unc_wr", rd, wba);
        check("unc_burst", s_last.burst, BURST_FIXED);
        check("unc_len", s_last.len, MLEN1);
        check("unc_is_write", s_last.is_write, 1);
        check("unc_size", s_last.size, MSIZE4);
        check("unc_addr", s_last.addr, 64'h1000_0000);
`ifdef DCACHE_STATS_EN
        check("unc_hit_cnt", hit_cnt, exp_hits);
        check("unc_miss_cnt", miss_cnt, exp_misses);
`endif

        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 9) == 0)
                a = 64'h1000_0000 + 64'($urandom_range(0, 7)) * 8;
            else
                a = 64'h8000_0000 + 64'($urandom_range(0, 5)) * 1024
                    + 64'($urandom_range(0, 3)) * 128 + 64'($urandom_range(0, 15)) * 8;
            s = ($urandom_range(0, 9) < 4) ? 8'($urandom_range(1, 255)) : 8'h00;
            d = {$urandom, $urandom};
            access(a, s, d, MSIZE8, 0, "rnd", rd, wba);
        end
`ifdef DCACHE_STATS_EN
        check("rnd_hit_cnt", hit_cnt, exp_hits);
        check("rnd_miss_cnt", miss_cnt, exp_misses);
`endif

        // reset in the middle of a refill burst
        a = 64'h8000_0000 + (64'd5 << 7) + 64'h18;
        dreq.valid = 1'b1; dreq.addr = a; dreq.size = MSIZE8; dreq.strobe = 8'h00; dreq.data = '0;
        n = 0;
        while (s_beat != 7 && n < LIMIT) begin
            @(negedge clk); #1; n++;
        end
        check("mid_beat7", s_beat, 7);
        @(posedge clk); #1;
        check("mid_pre_valid", creq.valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_creq_drop", creq.valid, 0);
        check("mid_addr_ok", dresp.addr_ok, 0);
        repeat (3) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        access(a, 8'h00, 64'h0, MSIZE8, SETS, "mid_reread", rd, wba);
        access(a, 8'h00, 64'h0, MSIZE8, 0, "mid_hit", rd, wba);
`ifdef DCACHE_STATS_EN
        check("mid_hit_cnt", hit_cnt, exp_hits);
        check("mid_miss_cnt", miss_cnt, exp_misses);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
